// File: rtl/cic_buf_pkg.sv
// Shared FSM type and default sizing for the CIC decimated-sample buffer.
package cic_buf_pkg;

    typedef enum logic {
        S_SETTLE = 1'b0,
        S_RUN    = 1'b1
    } cic_buf_state_t;

    localparam int CIC_BUF_NUMBITS = 25;
    localparam int CIC_BUF_DEPTH   = 8;
    localparam int CIC_BUF_COUNT_W = 16;

endpackage

// File: rtl/cic_buf_fifo.sv
// Synchronous word FIFO with extra-MSB pointers and a synchronous flush.
// Latency: a pushed word is visible at the head one cycle later; no fall-through.
// Backpressure: a push while full is refused unless a pop frees the slot in the same cycle.
module cic_buf_fifo
#(
    parameter int WIDTH = 25,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             rd_en;
    logic             wr_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rd_en = pop & ~empty;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign wr_en = push & (~full | rd_en);

    // Head reads as zero while empty so reset and flush present a clean bus.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/cic_sample_buffer.sv
// Captures CIC output words on divided-clock rises, drops settling words, queues the rest (CIC_BUF_AVG_EN adds averaging).
// Latency: strobe first sampled high at edge k, word in FIFO at edge k+2.
// Backpressure: valid/ready on the output; a full FIFO drops the word and sets sticky overflow.
module cic_sample_buffer
    import cic_buf_pkg::*;
#(
    parameter int NUMBITS  = CIC_BUF_NUMBITS,
    parameter int DEPTH    = CIC_BUF_DEPTH,
    parameter int DISCARD  = 3,
    parameter int AVG_LOG2 = 2
)
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUMBITS-1:0]         sample_in,
    input  logic                       sample_strobe,
    input  logic                       clear,
    output logic [NUMBITS-1:0]         out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic [CIC_BUF_COUNT_W-1:0] sample_count
);

    localparam int             DW         = (DISCARD > 1) ? $clog2(DISCARD) : 1;
    localparam logic [DW-1:0]  DISC_LAST  = DW'((DISCARD > 0) ? DISCARD - 1 : 0);
    localparam cic_buf_state_t INIT_STATE = (DISCARD == 0) ? S_RUN : S_SETTLE;

    logic               strobe_q;
    logic               rise;
    logic               armed;
    logic               cap_vld;
    logic [NUMBITS-1:0] cap_word;
    cic_buf_state_t     state;
    cic_buf_state_t     state_nxt;
    logic [DW-1:0]      discard_cnt;
    logic [DW-1:0]      discard_nxt;
    logic               in_run;
    logic               push;
    logic [NUMBITS-1:0] push_word;
    logic               pop;
    logic               full;
    logic               empty;

    assign rise   = sample_strobe & ~strobe_q;
    assign in_run = (state == S_RUN);
    assign pop    = out_valid & out_ready;

    // Capture waits one cycle after the rise so the CIC word has settled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            strobe_q <= 1'b0;
            armed    <= 1'b0;
            cap_vld  <= 1'b0;
            cap_word <= '0;
        end else begin
            strobe_q <= sample_strobe;
            armed    <= rise & ~clear;
            cap_vld  <= armed & ~clear;
            if (armed) cap_word <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= INIT_STATE;
            discard_cnt <= '0;
        end else begin
            state       <= state_nxt;
            discard_cnt <= discard_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard_cnt;
        case (state)
            S_SETTLE: begin
                if (cap_vld) begin
                    if (discard_cnt == DISC_LAST) begin
                        state_nxt   = S_RUN;
                        discard_nxt = '0;
                    end else begin
                        discard_nxt = discard_cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (clear) begin
            state_nxt   = INIT_STATE;
            discard_nxt = '0;
        end
    end

`ifdef CIC_BUF_AVG_EN
    localparam int SW = NUMBITS + AVG_LOG2;

    logic [SW-1:0]       acc;
    logic [SW-1:0]       acc_sum;
    logic [AVG_LOG2-1:0] avg_cnt;

    assign acc_sum   = acc + SW'(cap_word);
    assign push      = cap_vld & in_run & (&avg_cnt);
    assign push_word = NUMBITS'(acc_sum >> AVG_LOG2);

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            acc     <= '0;
            avg_cnt <= '0;
        end else if (cap_vld && in_run) begin
            avg_cnt <= avg_cnt + 1'b1;
            acc     <= (&avg_cnt) ? '0 : acc_sum;
        end
    end
`else
    assign push      = cap_vld & in_run;
    assign push_word = cap_word;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            overflow     <= 1'b0;
            sample_count <= '0;
        end else if (push) begin
            if (full && !pop) overflow <= 1'b1;
            else              sample_count <= sample_count + 1'b1;
        end
    end

    cic_buf_fifo #(
        .WIDTH (NUMBITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (clear),
        .push    (push),
        .wdata   (push_word),
        .pop     (out_ready),
        .rdata   (out_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign out_valid = ~empty;

endmodule

// File: tb/tb_cic_sample_buffer.sv
// Randomized bench for cic_sample_buffer: a queue-based model predicts accepted words, a monitor checks pops.
module tb_cic_sample_buffer;

    localparam int NB      = 25;
    localparam int DEPTH   = 8;
    localparam int DISCARD = 3;
    localparam int AVG     = 2;
    localparam int LW      = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset_n;
    logic [NB-1:0] sample_in;
    logic          sample_strobe;
    logic          clear;
    logic [NB-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          overflow;
    logic [15:0]   sample_count;

    cic_sample_buffer #(
        .NUMBITS  (NB),
        .DEPTH    (DEPTH),
        .DISCARD  (DISCARD),
        .AVG_LOG2 (AVG)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample_in     (sample_in),
        .sample_strobe (sample_strobe),
        .clear         (clear),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .level         (level),
        .overflow      (overflow),
        .sample_count  (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned   cyc;
        logic [NB-1:0] w;
    } pend_t;

    int            checks = 0;
    int            errors = 0;
    int unsigned   cyc = 0;
    pend_t         pend_q[$];
    logic [NB-1:0] exp_q[$];
    int            m_level = 0;
    bit            m_ovf = 1'b0;
    int unsigned   m_cnt = 0;
    int            m_disc = 0;
    longint        m_acc = 0;
    int            m_acnt = 0;
    bit            just_reset = 1'b1;
    bit            rnd_ready = 1'b0;
    int            ready_pct = 50;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_accept(input logic [NB-1:0] w, input bit pop);
        if (m_level < DEPTH || pop) begin
            exp_q.push_back(w);
            m_level++;
            m_cnt = (m_cnt + 1) % 65536;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    // Model: at each falling edge, check DUT state, then predict the next rising edge.
    initial begin : model
        pend_t p;
        bit    pop;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("level", 32'(level), 32'(m_level));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("sample_count", 32'(sample_count), m_cnt);
            check("out_valid", 32'(out_valid), 32'(m_level > 0));
            if (just_reset) check("out_data_after_reset", 32'(out_data), 32'd0);
            just_reset = 1'b0;
            if (!reset_n || clear) begin
                just_reset = !reset_n;
                pend_q.delete();
                exp_q.delete();
                m_level = 0;
                m_ovf   = 1'b0;
                m_cnt   = 0;
                m_disc  = 0;
                m_acc   = 0;
                m_acnt  = 0;
            end else begin
                pop = (m_level > 0) && out_ready;
                if (pend_q.size() > 0 && pend_q[0].cyc == cyc + 1) begin
                    p = pend_q.pop_front();
                    if (m_disc < DISCARD) begin
                        m_disc++;
                    end else begin
`ifdef CIC_BUF_AVG_EN
                        m_acc += longint'(p.w);
                        m_acnt++;
                        if (m_acnt == (1 << AVG)) begin
                            model_accept(NB'(m_acc / (1 << AVG)), pop);
                            m_acc  = 0;
                            m_acnt = 0;
                        end
`else
                        model_accept(p.w, pop);
`endif
                    end
                end
                if (pop) m_level--;
            end
        end
    end

    initial begin : monitor
        logic [NB-1:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && !clear && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e));
                end
            end
        end
    end

    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_word(input logic [NB-1:0] w, input int hi, input int lo);
        pend_t p;
        sample_in     = w;
        sample_strobe = 1'b1;
        p.cyc = cyc + 3;
        p.w   = w;
        pend_q.push_back(p);
        repeat (hi) tick();
        sample_strobe = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin : stim
        logic [NB-1:0] first;
        pend_t         p;
        reset_n       = 1'b0;
        sample_in     = '0;
        sample_strobe = 1'b0;
        clear         = 1'b0;
        out_ready     = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

`ifndef CIC_BUF_AVG_EN
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) strobe_word(NB'(10 + i), 1, 1);
        repeat (6) tick();
        check("settle_count", 32'(sample_count), 32'd2);
        check("settle_level", 32'(level), 32'd0);

        out_ready = 1'b0;
        first = NB'($urandom);
        strobe_word(first, 1, 1);
        for (int i = 0; i < 8; i++) strobe_word(NB'($urandom), 1, 1);
        repeat (3) tick();
        check("ovf_level", 32'(level), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", 32'(out_data), 32'(first));

        pulse_clear();
        for (int i = 0; i < 11; i++) strobe_word(NB'($urandom), 1, 1);
        repeat (3) tick();
        sample_in     = NB'($urandom);
        sample_strobe = 1'b1;
        p.cyc = cyc + 3;
        p.w   = sample_in;
        pend_q.push_back(p);
        tick();
        sample_strobe = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        check("pushpop_level", 32'(level), 32'd8);
        check("pushpop_ovf", 32'(overflow), 32'd0);

        sample_in     = NB'($urandom);
        sample_strobe = 1'b1;
        p.cyc = cyc + 3;
        p.w   = sample_in;
        pend_q.push_back(p);
        tick();
        sample_strobe = 1'b0;
        tick();
        pulse_clear();
        tick();
        check("clear_level", 32'(level), 32'd0);
        check("clear_ovf", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) strobe_word(NB'($urandom), 1, 1);
        repeat (4) tick();
`else
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) strobe_word(NB'($urandom), 1, 1);
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) strobe_word(NB'(4 * i), 1, 1);
        repeat (3) tick();
        check("avg_level", 32'(level), 32'd1);
        check("avg_value", 32'(out_data), 32'd10);
        out_ready = 1'b1;
        tick();
        pulse_clear();
`endif

        rnd_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i % 80 == 79) begin
                ready_pct = $urandom_range(10, 90);
                pulse_clear();
            end
            if (i == 200) begin
                reset_n = 1'b0;
                repeat (2) tick();
                reset_n = 1'b1;
            end
            strobe_word(NB'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
        end
        rnd_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (exp_q.size() > 0 || pend_q.size() > 0); i++) tick();
        check("drain_left", 32'(exp_q.size() + pend_q.size()), 32'd0);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
